// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: captures a word on load, sends it one
// bit per clock with a valid qualifier, then pulses done for one cycle.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d = pi;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Zero-filled shift toward whichever end drives sout.
        if (MSB_FIRST) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come from registered state only, so load/pi never reach them combinationally.
  logic out_bit;
  assign out_bit    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign ready      = (state_q == IDLE);
  assign sout_valid = (state_q == SHIFT);
  assign sout       = (state_q == SHIFT) ? out_bit : 1'b0;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: an MSB-first and an LSB-first instance checked
// against an index-based bit model and a loopback SIPO receiver.
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pi_m = 8'h00, pi_l = 8'h00;
  logic       load_m = 1'b0, load_l = 1'b0;
  logic       ready_m, sout_m, valid_m, done_m;
  logic       ready_l, sout_l, valid_l, done_l;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .pi(pi_m), .load(load_m),
    .ready(ready_m), .sout(sout_m), .sout_valid(valid_m), .done(done_m)
  );

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .pi(pi_l), .load(load_l),
    .ready(ready_l), .sout(sout_l), .sout_valid(valid_l), .done(done_l)
  );

  // Loopback receiver: 8-bit SIPO clocked from the MSB-first transmitter.
  logic [7:0] rx;
  always @(posedge clk or negedge rst) begin
    if (!rst) rx <= 8'h00;
    else if (valid_m) rx <= {rx[6:0], sout_m};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame; on entry the selected instance must be idle at a sample point.
  task automatic run_frame(input bit msb, input logic [7:0] word, input logic [7:0] pi_next,
                           input bit junk, input bit hold, output int acc_cyc);
    logic exp_bit;
    int   bad = 0;
    n_cmp++;
    if ((msb ? ready_m : ready_l) !== 1'b1) begin
      n_err++; bad++;
      $display("FAIL idle_ready: got %b expected 1", msb ? ready_m : ready_l);
    end
    if (msb) begin pi_m = word; load_m = 1'b1; end
    else     begin pi_l = word; load_l = 1'b1; end
    acc_cyc = cyc;
    tick();
    if (msb) begin pi_m = pi_next; load_m = hold; end
    else     begin pi_l = pi_next; load_l = hold; end
    for (int k = 0; k < 8; k++) begin
      exp_bit = msb ? word[7-k] : word[k];
      n_cmp++;
      if ((msb ? valid_m : valid_l) !== 1'b1 || (msb ? ready_m : ready_l) !== 1'b0 ||
          (msb ? done_m : done_l) !== 1'b0) begin
        n_err++; bad++;
        $display("FAIL shift_flags bit%0d: got valid=%b ready=%b done=%b expected 1 0 0", k,
                 msb ? valid_m : valid_l, msb ? ready_m : ready_l, msb ? done_m : done_l);
      end
      n_cmp++;
      if ((msb ? sout_m : sout_l) !== exp_bit) begin
        n_err++; bad++;
        $display("FAIL sout bit%0d word=%h: got %b expected %b", k, word,
                 msb ? sout_m : sout_l, exp_bit);
      end
      if (junk) begin
        if (msb) begin pi_m = 8'($urandom); load_m = 1'($urandom); end
        else     begin pi_l = 8'($urandom); load_l = 1'($urandom); end
      end
      tick();
    end
    n_cmp++;
    if ((msb ? done_m : done_l) !== 1'b1 || (msb ? valid_m : valid_l) !== 1'b0 ||
        (msb ? sout_m : sout_l) !== 1'b0 || (msb ? ready_m : ready_l) !== 1'b0) begin
      n_err++; bad++;
      $display("FAIL done_cycle: got done=%b valid=%b sout=%b ready=%b expected 1 0 0 0",
               msb ? done_m : done_l, msb ? valid_m : valid_l,
               msb ? sout_m : sout_l, msb ? ready_m : ready_l);
    end
    if (msb) begin
      n_cmp++;
      if (rx !== word) begin
        n_err++; bad++;
        $display("FAIL loopback_rx: got %h expected %h", rx, word);
      end
    end
    if (msb) begin pi_m = pi_next; load_m = hold; end
    else     begin pi_l = pi_next; load_l = hold; end
    tick();
    $display("frame %s word=%h accepted@%0d errors=%0d", msb ? "msb" : "lsb", word, acc_cyc, bad);
  endtask

  task automatic check_idle(input string tag);
    n_cmp++;
    if (ready_m !== 1'b1 || valid_m !== 1'b0 || sout_m !== 1'b0 || done_m !== 1'b0 ||
        ready_l !== 1'b1 || valid_l !== 1'b0 || sout_l !== 1'b0 || done_l !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got m=%b%b%b%b l=%b%b%b%b expected ready,valid,sout,done=1000",
               tag, ready_m, valid_m, sout_m, done_m, ready_l, valid_l, sout_l, done_l);
    end
  endtask

  task automatic test_reset();
    #2;
    check_idle("reset_t0");
    for (int i = 0; i < 6; i++) begin
      load_m = i[0]; load_l = ~i[0];
      pi_m = 8'($urandom); pi_l = 8'($urandom);
      tick();
      check_idle("reset_hold");
    end
    load_m = 1'b0; load_l = 1'b0;
    rst = 1'b1;
    tick();
    check_idle("reset_release");
    $display("reset test done");
  endtask

  task automatic test_msb_a5();
    int acc;
    run_frame(1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0, acc);
    check_idle("after_a5");
  endtask

  task automatic test_hold_load();
    int acc;
    // 0F is accepted, then load stays high with FF on pi: FF must wait for the next IDLE.
    run_frame(1'b1, 8'h0F, 8'hFF, 1'b0, 1'b1, acc);
    run_frame(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, acc);
    check_idle("after_hold");
  endtask

  task automatic test_abort();
    int acc;
    pi_m = 8'hFF; load_m = 1'b1;
    tick();
    load_m = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (sout_m !== 1'b1 || valid_m !== 1'b1) begin
        n_err++;
        $display("FAIL abort_pre bit%0d: got sout=%b valid=%b expected 1 1", k, sout_m, valid_m);
      end
      tick();
    end
    #2 rst = 1'b0;
    #1;
    check_idle("abort_immediate");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("abort_held");
    end
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("abort_wait_idle");
    end
    run_frame(1'b1, 8'h81, 8'h00, 1'b0, 1'b0, acc);
  endtask

  task automatic test_lsb_first();
    int acc;
    run_frame(1'b0, 8'h01, 8'h00, 1'b0, 1'b0, acc);
    run_frame(1'b0, 8'hB4, 8'h00, 1'b1, 1'b0, acc);
    load_l = 1'b0;
    check_idle("after_lsb");
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    run_frame(1'b1, 8'h3C, 8'hC3, 1'b0, 1'b1, acc1);
    run_frame(1'b1, 8'hC3, 8'hC3, 1'b0, 1'b0, acc2);
    n_cmp++;
    if (acc2 - acc1 !== 10) begin
      n_err++;
      $display("FAIL frame_period: got %0d expected 10", acc2 - acc1);
    end
  endtask

  task automatic test_random();
    int  acc;
    bit  msb;
    logic [7:0] w;
    for (int f = 0; f < 16; f++) begin
      msb = 1'($urandom);
      w   = 8'($urandom);
      run_frame(msb, w, 8'($urandom), 1'b1, 1'b0, acc);
      load_m = 1'b0; load_l = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        pi_m = 8'($urandom); pi_l = 8'($urandom);
        check_idle("random_gap");
        tick();
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_msb_a5();
    test_hold_load();
    test_abort();
    test_lsb_first();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
